// File: rtl/imem_boot_pkg.sv
// Shared types and sizing for the iDEA instruction memory and its byte-serial boot loader.
`ifndef IM_ADDR_WIDTH
`define IM_ADDR_WIDTH 9
`endif
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

package imem_boot_pkg;

    localparam int unsigned IM_ADDR_WIDTH         = `IM_ADDR_WIDTH;
    localparam int unsigned IM_DATA_WIDTH         = `DATAWIDTH;
    localparam int unsigned LOADER_BYTES_PER_WORD = 4;
    localparam int unsigned LEN_WIDTH             = 16;
    localparam int unsigned BYTE_CNT_WIDTH        = $clog2(LOADER_BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_RUN
    } state_t;

endpackage

// File: rtl/imem_boot_if.sv
// Fetch-port and loader-stream signals between the core/loader side and imem_boot.
interface imem_boot_if
    import imem_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = IM_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0] inst_o;
    logic                  core_rst_o;
    logic                  ld_valid_i;
    logic [7:0]            ld_data_i;
    logic                  ld_ready_o;
    logic                  ld_start_i;
    logic                  done_o;
    logic [ADDR_WIDTH:0]   words_o;

    modport master (
        output pc_i, ld_valid_i, ld_data_i, ld_start_i,
        input  inst_o, core_rst_o, ld_ready_o, done_o, words_o
    );

    modport slave (
        input  pc_i, ld_valid_i, ld_data_i, ld_start_i,
        output inst_o, core_rst_o, ld_ready_o, done_o, words_o
    );
endinterface

// File: rtl/imem_boot_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port with output clear.
module imem_ram #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register clears when not reading, mapping to the block RAM output reset.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        else    rdata <= '0;
    end
endmodule

// File: rtl/imem_boot.sv
// Instruction memory responder with boot loader: holds the core in reset while a
// length-prefixed byte stream fills the memory, then serves fetches.
module imem_boot
    import imem_boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = IM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = IM_DATA_WIDTH,
    parameter int unsigned DEPTH      = 2 ** IM_ADDR_WIDTH
) (
    input logic       clk,
    input logic       rst,
    imem_boot_if.slave bus
);
    localparam int unsigned WCNT_WIDTH = ADDR_WIDTH + 1;

    state_t                    state_q, state_d;
    logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]     asm_q, asm_d;
    logic [7:0]                len_hi_q, len_hi_d;
    logic [LEN_WIDTH-1:0]      rem_q, rem_d;
    logic [WCNT_WIDTH-1:0]     waddr_q, waddr_d;
    logic [WCNT_WIDTH-1:0]     words_q;
    logic                      ld_ready_q, core_rst_q, done_q;

    logic                      xfer_c, we_c, re_c;
    logic [DATA_WIDTH-1:0]     wdata_c;
    logic [LEN_WIDTH-1:0]      len_c;

    assign xfer_c  = bus.ld_valid_i && ld_ready_q;
    assign wdata_c = {asm_q[DATA_WIDTH-9:0], bus.ld_data_i};
    assign len_c   = {len_hi_q, bus.ld_data_i};
    assign re_c    = !rst && (state_q == ST_RUN);

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        len_hi_d   = len_hi_q;
        rem_d      = rem_q;
        waddr_d    = waddr_q;
        we_c       = 1'b0;
        unique case (state_q)
            ST_LEN_HI: begin
                if (xfer_c) begin
                    len_hi_d = bus.ld_data_i;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer_c) begin
                    rem_d   = len_c;
                    state_d = (len_c == '0) ? ST_RUN : ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer_c) begin
                    asm_d      = wdata_c;
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_WIDTH'(1);
                    if (byte_cnt_q == BYTE_CNT_WIDTH'(LOADER_BYTES_PER_WORD - 1)) begin
                        byte_cnt_d = '0;
                        rem_d      = rem_q - LEN_WIDTH'(1);
                        // Words past the end are consumed but dropped; waddr saturates.
                        if (waddr_q != WCNT_WIDTH'(DEPTH)) begin
                            we_c    = 1'b1;
                            waddr_d = waddr_q + WCNT_WIDTH'(1);
                        end
                        if (rem_q == LEN_WIDTH'(1)) state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.ld_start_i) begin
                    state_d    = ST_LEN_HI;
                    byte_cnt_d = '0;
                    waddr_d    = '0;
                end
            end
            default: state_d = ST_LEN_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LEN_HI;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            len_hi_q   <= '0;
            rem_q      <= '0;
            waddr_q    <= '0;
            words_q    <= '0;
            ld_ready_q <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            len_hi_q   <= len_hi_d;
            rem_q      <= rem_d;
            waddr_q    <= waddr_d;
            ld_ready_q <= (state_d != ST_RUN);
            core_rst_q <= (state_d != ST_RUN);
            done_q     <= (state_d == ST_RUN);
            if (state_d == ST_RUN && state_q != ST_RUN) words_q <= waddr_d;
        end
    end

    imem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (waddr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata_c),
        .re    (re_c),
        .raddr (bus.pc_i),
        .rdata (bus.inst_o)
    );

    assign bus.core_rst_o = core_rst_q;
    assign bus.ld_ready_o = ld_ready_q;
    assign bus.done_o     = done_q;
    assign bus.words_o    = words_q;
endmodule

// File: tb/tb_imem_boot.sv
// Directed bench for imem_boot: loads, gaps, N=0, overflow, mid-load reset and reload.
module tb_imem_boot;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    imem_boot_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus ();

    imem_boot #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .DEPTH(512)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one byte and waits (bounded) until it is accepted; optional idle gap after.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.ld_valid_i = 1'b1;
        bus.ld_data_i  = b;
        while (bus.ld_ready_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            vectors++;
            errors++;
            $display("FAIL send_byte_timeout: ready=%b want 1 for byte %02h", bus.ld_ready_o, b);
        end
        tick();
        bus.ld_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic read_word(input logic [8:0] pc, output logic [31:0] inst);
        bus.pc_i = pc;
        tick();
        inst = bus.inst_o;
    endtask

    task automatic pulse_start();
        bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (bus.core_rst_o !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", bus.core_rst_o); end
        vectors++;
        if (bus.ld_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ld_ready_o); end
        vectors++;
        if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        vectors++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", bus.inst_o); end
        vectors++;
        if (bus.words_o !== 10'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", bus.words_o); end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.ld_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.ld_ready_o); end
    endtask

    task automatic test_load_n2();
        logic [7:0]  stream [10];
        logic [31:0] inst;
        stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus.ld_ready_o !== 1'b1) begin errors++; $display("FAIL n2_ready byte %0d: got %b want 1", i, bus.ld_ready_o); end
            if (i == 9) begin
                vectors++;
                if (bus.core_rst_o !== 1'b1) begin errors++; $display("FAIL n2_core_rst_before_last: got %b want 1", bus.core_rst_o); end
            end
            send_byte(stream[i], 0);
        end
        vectors++;
        if (bus.core_rst_o !== 1'b0) begin errors++; $display("FAIL n2_core_rst_after: got %b want 0", bus.core_rst_o); end
        vectors++;
        if (bus.done_o !== 1'b1) begin errors++; $display("FAIL n2_done: got %b want 1", bus.done_o); end
        vectors++;
        if (bus.ld_ready_o !== 1'b0) begin errors++; $display("FAIL n2_ready_run: got %b want 0", bus.ld_ready_o); end
        vectors++;
        if (bus.words_o !== 10'd2) begin errors++; $display("FAIL n2_words: got %0d want 2", bus.words_o); end
        read_word(9'd0, inst);
        vectors++;
        if (inst !== 32'hDEADBEEF) begin errors++; $display("FAIL n2_mem0: got %h want deadbeef", inst); end
        read_word(9'd1, inst);
        vectors++;
        if (inst !== 32'h12345678) begin errors++; $display("FAIL n2_mem1: got %h want 12345678", inst); end
    endtask

    task automatic test_reload();
        bus.pc_i = 9'd0;
        pulse_start();
        vectors++;
        if (bus.core_rst_o !== 1'b1) begin errors++; $display("FAIL reload_core_rst: got %b want 1", bus.core_rst_o); end
        vectors++;
        if (bus.ld_ready_o !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b want 1", bus.ld_ready_o); end
        vectors++;
        if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reload_done: got %b want 0", bus.done_o); end
        tick();
        vectors++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL reload_inst_masked: got %h want 0", bus.inst_o); end
    endtask

    task automatic test_gapped();
        logic [31:0] inst;
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        vectors++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL gap_inst_masked: got %h want 0", bus.inst_o); end
        send_word(32'h11223344, 1);
        send_word(32'h55667788, 1);
        vectors++;
        if (bus.done_o !== 1'b1) begin errors++; $display("FAIL gap_done: got %b want 1", bus.done_o); end
        vectors++;
        if (bus.words_o !== 10'd2) begin errors++; $display("FAIL gap_words: got %0d want 2", bus.words_o); end
        read_word(9'd0, inst);
        vectors++;
        if (inst !== 32'h11223344) begin errors++; $display("FAIL gap_mem0: got %h want 11223344", inst); end
        read_word(9'd1, inst);
        vectors++;
        if (inst !== 32'h55667788) begin errors++; $display("FAIL gap_mem1: got %h want 55667788", inst); end
    endtask

    task automatic test_n0();
        logic [31:0] inst;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        vectors++;
        if (bus.done_o !== 1'b1) begin errors++; $display("FAIL n0_done: got %b want 1", bus.done_o); end
        vectors++;
        if (bus.core_rst_o !== 1'b0) begin errors++; $display("FAIL n0_core_rst: got %b want 0", bus.core_rst_o); end
        vectors++;
        if (bus.words_o !== 10'd0) begin errors++; $display("FAIL n0_words: got %0d want 0", bus.words_o); end
        read_word(9'd0, inst);
        vectors++;
        if (inst !== 32'h11223344) begin errors++; $display("FAIL n0_mem0: got %h want 11223344", inst); end
    endtask

    task automatic test_overflow();
        logic [31:0] inst;
        logic [8:0]  pcs [4];
        pcs = '{9'd0, 9'd1, 9'd256, 9'd511};
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 514; i++) send_word(32'(i), 0);
        vectors++;
        if (bus.done_o !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b want 1", bus.done_o); end
        vectors++;
        if (bus.words_o !== 10'd512) begin errors++; $display("FAIL ovf_words: got %0d want 512", bus.words_o); end
        for (int i = 0; i < 4; i++) begin
            read_word(pcs[i], inst);
            vectors++;
            if (inst !== 32'(pcs[i])) begin errors++; $display("FAIL ovf_mem%0d: got %h want %h", pcs[i], inst, 32'(pcs[i])); end
        end
    endtask

    task automatic test_rst_midload();
        logic [31:0] inst;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.core_rst_o !== 1'b1) begin errors++; $display("FAIL midrst_core_rst: got %b want 1", bus.core_rst_o); end
        vectors++;
        if (bus.inst_o !== 32'h0) begin errors++; $display("FAIL midrst_inst: got %h want 0", bus.inst_o); end
        rst = 1'b0;
        tick();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hCA, 0);
        // A start request outside RUN must not disturb the load in progress.
        pulse_start();
        send_byte(8'hFE, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h0D, 0);
        vectors++;
        if (bus.done_o !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", bus.done_o); end
        vectors++;
        if (bus.words_o !== 10'd1) begin errors++; $display("FAIL midrst_words: got %0d want 1", bus.words_o); end
        read_word(9'd0, inst);
        vectors++;
        if (inst !== 32'hCAFEF00D) begin errors++; $display("FAIL midrst_mem0: got %h want cafef00d", inst); end
        read_word(9'd1, inst);
        vectors++;
        if (inst !== 32'h00000001) begin errors++; $display("FAIL midrst_mem1_kept: got %h want 00000001", inst); end
    endtask

    initial begin
        vectors        = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.pc_i       = '0;
        bus.ld_valid_i = 1'b0;
        bus.ld_data_i  = '0;
        bus.ld_start_i = 1'b0;
        test_reset();
        test_load_n2();
        test_reload();
        test_gapped();
        test_n0();
        test_overflow();
        test_rst_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/imem_boot.md
# imem_boot

Instruction-memory responder and boot loader for the iDEA core. It answers the fetch stage's program-counter requests with registered instruction words. Out of reset it holds the core in reset while a byte-serial loader stream fills the memory. Once loading finishes it releases the core, and the core then fetches from address 0.

## Interface
Parameters:
- ADDR_WIDTH, 9: instruction address width; equals `im_addr_width`.
- DATA_WIDTH, 32: instruction width; equals `datawidth`.
- DEPTH, 512: number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc_i  in  ADDR_WIDTH  fetch address from the fetch stage.
- inst_o  out  DATA_WIDTH  instruction word for the previous cycle's pc_i.
- core_rst_o  out  1  reset to the core; high while loading.
- ld_valid_i  in  1  loader byte valid.
- ld_data_i  in  8  loader byte.
- ld_ready_o  out  1  loader byte accepted when ld_valid_i && ld_ready_o.
- ld_start_i  in  1  single-cycle pulse; requests a reload while in RUN.
- done_o  out  1  high in RUN.
- words_o  out  ADDR_WIDTH+1  number of words written by the last load.

## Operation
- FSM states: LEN_HI, LEN_LO, DATA, RUN.
- Reset enters LEN_HI. Reset values:
  - core_rst_o=1, ld_ready_o=0 during rst, done_o=0, inst_o=0, words_o=0.
  - Byte counter and write address are 0.
  - Memory contents are not cleared.
- Handshake:
  - ld_ready_o=1 in LEN_HI, LEN_LO and DATA from the first cycle after rst deasserts; 0 in RUN.
  - A byte transfers when ld_valid_i && ld_ready_o. ld_valid_i with ready low is ignored; nothing is buffered.
- LEN_HI / LEN_LO: capture a 16-bit word count N, MSB byte first. Next state is DATA if N>0. If N==0, go straight to RUN with words_o=0.
- DATA:
  - Each instruction word is 4 bytes, MSB first, shifted into a 32-bit assembly register.
  - On the 4th byte, write the assembled word (including that byte) to mem[waddr] in the same cycle, then increment waddr.
  - Words beyond DEPTH (waddr == DEPTH) are accepted and discarded. The address never wraps, and words_o saturates at DEPTH.
  - After the N-th word is written, go to RUN.
- RUN: core_rst_o=0, done_o=1.
  - ld_start_i=1 returns to LEN_HI, reasserts core_rst_o, and clears waddr and the byte counter.
  - ld_start_i outside RUN is ignored.
- Read port: inst_o <= mem[pc_i] every cycle while in RUN. In any other state inst_o is forced to 0.
- rst mid-load: the partial word is dropped, the FSM returns to LEN_HI, and already-written words remain in memory.

## Timing
- Read latency is 1 cycle: pc_i sampled at edge k gives inst_o valid after edge k. This matches the fetch stage, which registers pc and decodes inst one cycle later.
- A byte accepted at edge k updates state and assembly register at edge k. The 4th byte's word is written at edge k and is readable at edge k+1.
- Final byte accepted at edge k:
  - state becomes RUN at edge k;
  - core_rst_o falls and done_o rises in the cycle after edge k;
  - the core's first clocked pc=0 comes one cycle later.
- Reload pulse at edge k: core_rst_o=1 and ld_ready_o=1 from the cycle after edge k.
- No combinational path from ld_valid_i to ld_ready_o; ld_ready_o is a function of state only.
- Same-address read and write cannot coincide, because reads are masked outside RUN.

## Structure
- Shared package holds:
  - state encoding (ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_RUN);
  - LOADER_BYTES_PER_WORD = 4;
  - LEN_WIDTH = 16.
- Address and data widths come from the existing global defines (`im_addr_width`, `datawidth`).
- One sub-module, imem_ram: a simple dual-port synchronous RAM (one write port, one registered read port) that maps to block RAM. imem_boot instantiates it and contains the FSM, assembly register and counters.

## Test plan
- Load N=2: stream 00 02 DE AD BE EF 12 34 56 78 with valid held high.
  - ld_ready_o=1 throughout.
  - core_rst_o falls one cycle after the last byte; words_o=2.
  - pc_i=0 → inst_o=DEADBEEF; pc_i=1 → inst_o=12345678; each one cycle later.
- Gapped valid: same stream with ld_valid_i low on alternate cycles → identical memory contents; no byte dropped or duplicated.
- N=0: stream 00 00 → RUN the cycle after, words_o=0; pc_i=0 returns the prior contents of mem[0].
- Overflow: N=514 with word i = i → mem[511]=511, words_o=512; 2 extra words accepted and discarded; mem[0]=0 unchanged.
- rst after 2 bytes of a word:
  - FSM back in LEN_HI, core_rst_o=1, inst_o=0.
  - New load with N=1, word 0xCAFEF00D → mem[0]=CAFEF00D.
- Reload: ld_start_i pulse in RUN → core_rst_o=1 and ld_ready_o=1 the next cycle; inst_o=0 until the new load completes.
